// File: rtl/approx_mult_pkg.sv
// Shared types and width helpers for the approximate-multiplier error monitor.
package approx_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 4;

    // Accumulator widths derived from the operand width.
    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    function automatic int cnt_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int sum_w(input int w);
        return 4 * w;
    endfunction

    function automatic int serr_w(input int w);
        return 4 * w + 1;
    endfunction

endpackage

// File: rtl/op_delay_line.sv
// PIPE_LAT-deep shift register carrying the {a, x, valid} tag alongside the
// multiplier pipeline; collapses to wires when PIPE_LAT is 0.
module op_delay_line #(
    parameter int WIDTH    = 4,
    parameter int PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] x_out,
    output logic             valid_out
);

    generate
        if (PIPE_LAT == 0) begin : g_pass
            assign a_out     = a_in;
            assign x_out     = x_in;
            assign valid_out = valid_in;
        end else begin : g_pipe
            logic [PIPE_LAT-1:0][2*WIDTH:0] stage;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage <= '0;
                end else begin
                    stage[0] <= {a_in, x_in, valid_in};
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign {a_out, x_out, valid_out} = stage[PIPE_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/approx_err_monitor.sv
// Exhaustive on-chip accuracy sweep around a WIDTHxWIDTH approximate multiplier.
// Optional signed bias accumulator sum_err is enabled by APPROX_ERR_BIAS_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start, results cleared
// ST_SWEEP | driving operand pair idx, one per cycle
// ST_DRAIN | flushing PIPE_LAT in-flight products
// ST_DONE  | results valid and held until next start
module approx_err_monitor
    import approx_mult_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PIPE_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_x,
    input  logic [2*WIDTH-1:0]   prod_in,
    output logic [2*WIDTH:0]     err_count,
    output logic [4*WIDTH-1:0]   sum_ed,
    output logic [2*WIDTH-1:0]   max_ed,
    output logic [WIDTH-1:0]     worst_a,
    output logic [WIDTH-1:0]     worst_x
`ifdef APPROX_ERR_BIAS_EN
    ,
    output logic signed [4*WIDTH:0] sum_err
`endif
);

    localparam int PW      = prod_w(WIDTH);
    localparam int CW      = cnt_w(WIDTH);
    localparam int SW      = sum_w(WIDTH);
    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    state_t               state, state_nxt;
    logic [PW-1:0]        idx, idx_nxt;
    logic [DRAIN_W-1:0]   drain_cnt, drain_nxt;
    logic                 clear_acc;
    logic                 sweeping;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        drain_nxt = drain_cnt;
        clear_acc = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_SWEEP;
                    idx_nxt   = '0;
                    clear_acc = 1'b1;
                end
            end
            ST_SWEEP: begin
                idx_nxt = idx + PW'(1);
                if (idx == {PW{1'b1}}) begin
                    if (PIPE_LAT > 0) begin
                        state_nxt = ST_DRAIN;
                        drain_nxt = DRAIN_W'(PIPE_LAT - 1);
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = ST_DONE;
                end else begin
                    drain_nxt = drain_cnt - DRAIN_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign sweeping = (state == ST_SWEEP);
    assign busy     = sweeping || (state == ST_DRAIN);
    assign done     = (state == ST_DONE);
    assign op_a     = sweeping ? idx[PW-1:WIDTH] : '0;
    assign op_x     = sweeping ? idx[WIDTH-1:0]  : '0;

    // Tag of the pair whose product is currently on prod_in.
    logic [WIDTH-1:0] tag_a, tag_x;
    logic             tag_v;

    generate
        if (PIPE_LAT > 0) begin : g_dly
            op_delay_line #(
                .WIDTH    (WIDTH),
                .PIPE_LAT (PIPE_LAT)
            ) u_op_delay_line (
                .clk       (clk),
                .rst_n     (rst_n),
                .a_in      (op_a),
                .x_in      (op_x),
                .valid_in  (sweeping),
                .a_out     (tag_a),
                .x_out     (tag_x),
                .valid_out (tag_v)
            );
        end else begin : g_comb
            assign tag_a = op_a;
            assign tag_x = op_x;
            assign tag_v = sweeping;
        end
    endgenerate

    logic [PW-1:0] exact;
    logic [PW-1:0] ed;

    assign exact = {{WIDTH{1'b0}}, tag_a} * {{WIDTH{1'b0}}, tag_x};
    assign ed    = (prod_in >= exact) ? (prod_in - exact) : (exact - prod_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
            worst_a   <= '0;
            worst_x   <= '0;
        end else if (clear_acc) begin
            err_count <= '0;
            sum_ed    <= '0;
            max_ed    <= '0;
            worst_a   <= '0;
            worst_x   <= '0;
        end else if (tag_v) begin
            err_count <= err_count + {{(CW-1){1'b0}}, |ed};
            sum_ed    <= sum_ed + {{(SW-PW){1'b0}}, ed};
            // Strict compare keeps the earliest pair on ties.
            if (ed > max_ed) begin
                max_ed  <= ed;
                worst_a <= tag_a;
                worst_x <= tag_x;
            end
        end
    end

`ifdef APPROX_ERR_BIAS_EN
    logic signed [PW:0] err_s;

    assign err_s = $signed({1'b0, prod_in}) - $signed({1'b0, exact});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_err <= '0;
        end else if (clear_acc) begin
            sum_err <= '0;
        end else if (tag_v) begin
            sum_err <= sum_err + {{(SW-PW){err_s[PW]}}, err_s};
        end
    end
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// Self-checking bench: emulated multipliers (exact, stuck LSB, zero, random noise)
// with statistics recomputed from a plain exhaustive reference loop.
module tb_approx_err_monitor;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic start0, start2;
    int   mode;
    logic [7:0] noise [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic        busy0, done0, busy2, done2;
    logic [3:0]  op_a0, op_x0, op_a2, op_x2;
    logic [7:0]  prod0, prod2, p2_s1;
    logic [8:0]  err_count0, err_count2;
    logic [15:0] sum_ed0, sum_ed2;
    logic [7:0]  max_ed0, max_ed2;
    logic [3:0]  worst_a0, worst_x0, worst_a2, worst_x2;
`ifdef APPROX_ERR_BIAS_EN
    logic signed [16:0] sum_err0, sum_err2;
`endif

    function automatic logic [7:0] prod_fn(input int m, input logic [3:0] a, input logic [3:0] x);
        logic [7:0] p;
        p = 8'(a) * 8'(x);
        case (m)
            1:       return {p[7:1], 1'b0};
            2:       return 8'd0;
            3:       return p ^ noise[{a, x}];
            default: return p;
        endcase
    endfunction

    always_comb prod0 = prod_fn(mode, op_a0, op_x0);

    // Two-stage registered multiplier for the PIPE_LAT = 2 instance.
    always_ff @(posedge clk) begin
        p2_s1 <= prod_fn(mode, op_a2, op_x2);
        prod2 <= p2_s1;
    end

    approx_err_monitor #(.WIDTH(W), .PIPE_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
        .op_a(op_a0), .op_x(op_x0), .prod_in(prod0),
        .err_count(err_count0), .sum_ed(sum_ed0), .max_ed(max_ed0),
        .worst_a(worst_a0), .worst_x(worst_x0)
`ifdef APPROX_ERR_BIAS_EN
        , .sum_err(sum_err0)
`endif
    );

    approx_err_monitor #(.WIDTH(W), .PIPE_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .op_a(op_a2), .op_x(op_x2), .prod_in(prod2),
        .err_count(err_count2), .sum_ed(sum_ed2), .max_ed(max_ed2),
        .worst_a(worst_a2), .worst_x(worst_x2)
`ifdef APPROX_ERR_BIAS_EN
        , .sum_err(sum_err2)
`endif
    );

    // Reference statistics over the first n pairs of the sweep order.
    int      r_ec, r_se, r_me, r_wa, r_wx;
    longint  r_serr;

    task automatic compute_ref(input int m, input int n);
        int e, d;
        r_ec = 0; r_se = 0; r_me = 0; r_wa = 0; r_wx = 0; r_serr = 0;
        for (int a = 0; a < 16; a++) begin
            for (int x = 0; x < 16; x++) begin
                if (a * 16 + x < n) begin
                    e = int'(prod_fn(m, 4'(a), 4'(x))) - a * x;
                    d = (e < 0) ? -e : e;
                    if (d != 0) r_ec++;
                    r_se   += d;
                    r_serr += e;
                    if (d > r_me) begin
                        r_me = d; r_wa = a; r_wx = x;
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_results(input int which, input int m, input string tag);
        compute_ref(m, 256);
        if (which == 0) begin
            check({tag, ".err_count"}, longint'(err_count0), r_ec);
            check({tag, ".sum_ed"},    longint'(sum_ed0),    r_se);
            check({tag, ".max_ed"},    longint'(max_ed0),    r_me);
            check({tag, ".worst_a"},   longint'(worst_a0),   r_wa);
            check({tag, ".worst_x"},   longint'(worst_x0),   r_wx);
`ifdef APPROX_ERR_BIAS_EN
            check({tag, ".sum_err"},   longint'(sum_err0),   r_serr);
`endif
        end else begin
            check({tag, ".err_count"}, longint'(err_count2), r_ec);
            check({tag, ".sum_ed"},    longint'(sum_ed2),    r_se);
            check({tag, ".max_ed"},    longint'(max_ed2),    r_me);
            check({tag, ".worst_a"},   longint'(worst_a2),   r_wa);
            check({tag, ".worst_x"},   longint'(worst_x2),   r_wx);
`ifdef APPROX_ERR_BIAS_EN
            check({tag, ".sum_err"},   longint'(sum_err2),   r_serr);
`endif
        end
    endtask

    // Pulse start, count busy cycles until done; returns with done sampled.
    task automatic run_sweep(input int which, output int busy_n);
        int guard;
        busy_n = 0;
        guard  = 0;
        @(negedge clk);
        if (which == 0) start0 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start2 = 1'b0;
        forever begin
            @(negedge clk);
            if ((which == 0) ? done0 : done2) break;
            if ((which == 0) ? busy0 : busy2) busy_n++;
            guard++;
            if (guard > 1000) begin
                check("sweep_timeout", 0, 1);
                break;
            end
        end
    endtask

    initial begin
        int n;
        int guard;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start2 = 1'b0;
        mode   = 0;
        foreach (noise[i]) noise[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;

        // Reset state.
        #12;
        check("rst.busy", longint'(busy0), 0);
        check("rst.done", longint'(done0), 0);
        check("rst.ops",  longint'({op_a0, op_x0}), 0);
        check("rst.err_count", longint'(err_count0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: exact multiplier.
        mode = 0;
        run_sweep(0, n);
        check("s1.busy_cycles", n, 256);
        check("s1.done", longint'(done0), 1);
        check_results(0, 0, "s1");

        // Scenario 2: stuck LSB.
        mode = 1;
        run_sweep(0, n);
        check("s2.busy_cycles", n, 256);
        check("s2.err_count_const", longint'(err_count0), 64);
        check("s2.sum_ed_const",    longint'(sum_ed0), 64);
        check("s2.worst_const",     longint'({worst_a0, worst_x0}), 8'h11);
        check_results(0, 1, "s2");

        // Scenario 3: product tied to zero.
        mode = 2;
        run_sweep(0, n);
        check("s3.err_count_const", longint'(err_count0), 225);
        check("s3.sum_ed_const",    longint'(sum_ed0), 14400);
        check("s3.max_ed_const",    longint'(max_ed0), 225);
        check("s3.worst_const",     longint'({worst_a0, worst_x0}), 8'hFF);
`ifdef APPROX_ERR_BIAS_EN
        check("s3.sum_err_const",   longint'(sum_err0), -14400);
`endif
        check_results(0, 2, "s3");

        // Random-noise multiplier, then hold in DONE with results stable.
        mode = 3;
        run_sweep(0, n);
        check("rnd.busy_cycles", n, 256);
        check_results(0, 3, "rnd");
        repeat (5) @(negedge clk);
        check("rnd.done_hold", longint'(done0), 1);
        check_results(0, 3, "rnd_hold");

        // Scenario 4: reset mid-sweep at idx 100.
        mode = 2;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ({op_a0, op_x0} != 8'd100 && guard < 400);
        check("s4.reached_idx100", longint'({op_a0, op_x0}), 100);
        compute_ref(2, 100);
        check("s4.partial_err_count", longint'(err_count0), r_ec);
        check("s4.partial_sum_ed",    longint'(sum_ed0), r_se);
        rst_n = 1'b0;
        #1;
        check("s4.rst_busy",      longint'(busy0), 0);
        check("s4.rst_done",      longint'(done0), 0);
        check("s4.rst_ops",       longint'({op_a0, op_x0}), 0);
        check("s4.rst_err_count", longint'(err_count0), 0);
        check("s4.rst_sum_ed",    longint'(sum_ed0), 0);
        check("s4.rst_max_ed",    longint'(max_ed0), 0);
        check("s4.rst_worst",     longint'({worst_a0, worst_x0}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        run_sweep(0, n);
        check("s4.restart_busy_cycles", n, 256);
        check_results(0, 0, "s4_restart");

        // Scenario 5: start held high across a whole sweep.
        mode = 1;
        @(negedge clk);
        start0 = 1'b1;
        n = 0;
        guard = 0;
        forever begin
            @(negedge clk);
            if (done0) break;
            if (busy0) n++;
            guard++;
            if (guard > 1000) begin
                check("s5.timeout", 0, 1);
                break;
            end
        end
        check("s5.busy_cycles", n, 256);
        check_results(0, 1, "s5");
        @(negedge clk);
        check("s5.restart_done",      longint'(done0), 0);
        check("s5.restart_busy",      longint'(busy0), 1);
        check("s5.restart_err_count", longint'(err_count0), 0);
        check("s5.restart_max_ed",    longint'(max_ed0), 0);
        start0 = 1'b0;
        guard = 0;
        while (!done0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("s5.second_done", longint'(done0), 1);
        check_results(0, 1, "s5_second");

        // Scenario 6: PIPE_LAT = 2 with a registered multiplier.
        mode = 0;
        run_sweep(2, n);
        check("s6.busy_cycles", n, 258);
        check_results(2, 0, "s6");
        mode = 3;
        run_sweep(2, n);
        check("s6r.busy_cycles", n, 258);
        check_results(2, 3, "s6r");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
